// File: rtl/rv_multicycle_ctrl_exec_if.sv
// Control/execute bus between the multi-cycle core datapath and its control slice.
// Core (master) supplies instruction and operands; the slice returns state, strobes and ALU results.
interface rv_multicycle_ctrl_exec_if;
  logic [31:0] instruction;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [2:0]  state;
  logic        pc_write;
  logic        reg_write_enable;
  logic        alu_sel_a;
  logic        alu_sel_b;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic        mem_to_reg;
  logic        take_jump_next;
  logic [31:0] alu_result;
  logic        zero_flag;
  logic [31:0] immediate;

  modport master (
    output instruction, src_a, src_b,
    input  state, pc_write, reg_write_enable, alu_sel_a, alu_sel_b,
           mem_read_enable, mem_write_enable, mem_to_reg, take_jump_next,
           alu_result, zero_flag, immediate
  );

  modport slave (
    input  instruction, src_a, src_b,
    output state, pc_write, reg_write_enable, alu_sel_a, alu_sel_b,
           mem_read_enable, mem_write_enable, mem_to_reg, take_jump_next,
           alu_result, zero_flag, immediate
  );
endinterface

// File: rtl/rv_multicycle_ctrl_exec.sv
// RV32I multi-cycle control FSM, ALU, branch comparator and immediate generator.
// Only the state is registered (4-5 cycles/instruction); all other outputs are combinational, no backpressure.
module rv_multicycle_ctrl_exec (
  input logic                     clk,
  input logic                     resetn,
  rv_multicycle_ctrl_exec_if.slave bus
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [2:0] {
    ST_IF = 3'd0, ST_ID = 3'd1, ST_EX = 3'd2, ST_ME = 3'd3, ST_WB = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_t;

  state_t      state_q;
  alu_op_t     alu_op;
  logic [31:0] ins;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [31:0] imm;
  logic [31:0] alu_res;
  logic        br_cond;
  logic        is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
  logic        pc_write, reg_write, sel_a, sel_b, mem_rd, mem_wr, mem_to_reg, take_jump;

  assign ins      = bus.instruction;
  assign opcode   = ins[6:0];
  assign funct3   = ins[14:12];
  assign funct7_5 = ins[30];

  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_ld    = (opcode == OP_LD);
  assign is_st    = (opcode == OP_ST);
  assign is_br    = (opcode == OP_BR);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);
  assign is_lui   = (opcode == OP_LUI);
  assign is_auipc = (opcode == OP_AUIPC);

  always_comb begin
    imm = 32'd0;
    case (opcode)
      OP_I, OP_LD, OP_JALR: imm = {{20{ins[31]}}, ins[31:20]};
      OP_ST:                imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OP_BR:                imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OP_LUI, OP_AUIPC:     imm = {ins[31:12], 12'd0};
      OP_JAL:               imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default:              imm = 32'd0;
    endcase
  end

  // IF uses the ALU for PC+4; EX address/link arithmetic for memory and jumps is always ADD.
  always_comb begin
    alu_op = ALU_ADD;
    if (state_q == ST_IF) begin
      alu_op = ALU_ADD;
    end else if (is_lui) begin
      alu_op = ALU_PASSB;
    end else if (state_q == ST_EX && (is_ld || is_st || is_jal || is_jalr || is_auipc)) begin
      alu_op = ALU_ADD;
    end else if (is_br) begin
      alu_op = ALU_SUB;
    end else begin
      case (funct3)
        3'b000:  alu_op = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_op = ALU_SLL;
        3'b010:  alu_op = ALU_SLT;
        3'b011:  alu_op = ALU_SLTU;
        3'b100:  alu_op = ALU_XOR;
        3'b101:  alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
        3'b110:  alu_op = ALU_OR;
        default: alu_op = ALU_AND;
      endcase
    end
  end

  always_comb begin
    alu_res = 32'd0;
    case (alu_op)
      ALU_ADD:   alu_res = bus.src_a + bus.src_b;
      ALU_SUB:   alu_res = bus.src_a - bus.src_b;
      ALU_SLL:   alu_res = bus.src_a << bus.src_b[4:0];
      ALU_SLT:   alu_res = {31'd0, $signed(bus.src_a) < $signed(bus.src_b)};
      ALU_SLTU:  alu_res = {31'd0, bus.src_a < bus.src_b};
      ALU_XOR:   alu_res = bus.src_a ^ bus.src_b;
      ALU_SRL:   alu_res = bus.src_a >> bus.src_b[4:0];
      ALU_SRA:   alu_res = $unsigned($signed(bus.src_a) >>> bus.src_b[4:0]);
      ALU_OR:    alu_res = bus.src_a | bus.src_b;
      ALU_AND:   alu_res = bus.src_a & bus.src_b;
      ALU_PASSB: alu_res = bus.src_b;
      default:   alu_res = 32'd0;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      3'b000:  br_cond = (bus.src_a == bus.src_b);
      3'b001:  br_cond = (bus.src_a != bus.src_b);
      3'b100:  br_cond = ($signed(bus.src_a) <  $signed(bus.src_b));
      3'b101:  br_cond = ($signed(bus.src_a) >= $signed(bus.src_b));
      3'b110:  br_cond = (bus.src_a <  bus.src_b);
      3'b111:  br_cond = (bus.src_a >= bus.src_b);
      default: br_cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IF;
    end else begin
      case (state_q)
        ST_IF:   state_q <= ST_ID;
        ST_ID:   state_q <= ST_EX;
        ST_EX:   state_q <= (is_ld || is_st) ? ST_ME : ST_WB;
        ST_ME:   state_q <= is_ld ? ST_WB : ST_IF;
        default: state_q <= ST_IF;
      endcase
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    sel_a      = 1'b0;
    sel_b      = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_to_reg = 1'b0;
    take_jump  = 1'b0;
    case (state_q)
      ST_IF: begin
        sel_a  = 1'b1;
        sel_b  = 1'b1;
        mem_rd = 1'b1;
      end
      ST_ID: begin
        sel_a = 1'b1;
        sel_b = 1'b1;
      end
      ST_EX: begin
        sel_a     = is_jal || is_auipc;
        sel_b     = is_i || is_ld || is_st || is_jalr || is_jal || is_auipc || is_lui;
        take_jump = is_jal || is_jalr || (is_br && br_cond);
      end
      ST_ME: begin
        mem_rd = is_ld;
        mem_wr = is_st;
      end
      ST_WB: begin
        pc_write   = 1'b1;
        reg_write  = is_r || is_i || is_ld || is_lui || is_auipc || is_jal || is_jalr;
        mem_to_reg = is_ld;
      end
      default: ;
    endcase
  end

  assign bus.state            = state_q;
  assign bus.pc_write         = pc_write;
  assign bus.reg_write_enable = reg_write;
  assign bus.alu_sel_a        = sel_a;
  assign bus.alu_sel_b        = sel_b;
  assign bus.mem_read_enable  = mem_rd;
  assign bus.mem_write_enable = mem_wr;
  assign bus.mem_to_reg       = mem_to_reg;
  assign bus.take_jump_next   = take_jump;
  assign bus.alu_result       = alu_res;
  assign bus.zero_flag        = (alu_res == 32'd0);
  assign bus.immediate        = imm;
endmodule

// File: tb/tb_rv_multicycle_ctrl_exec.sv
// Directed bench for rv_multicycle_ctrl_exec: hand-computed vectors per feature.
module tb_rv_multicycle_ctrl_exec;
  logic clk = 1'b0;
  logic resetn;
  int   errors = 0;
  int   checks = 0;

  rv_multicycle_ctrl_exec_if bus();

  rv_multicycle_ctrl_exec dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.instruction = 32'h002081B3;
    bus.src_a = 32'd0;
    bus.src_b = 32'd0;
    #2;
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", bus.state); end
    checks++; if (bus.mem_read_enable !== 1'b1) begin errors++; $display("FAIL rst_mem_rd got=%b exp=1", bus.mem_read_enable); end
    checks++; if ({bus.alu_sel_a, bus.alu_sel_b} !== 2'b11) begin errors++; $display("FAIL rst_sel got=%b exp=11", {bus.alu_sel_a, bus.alu_sel_b}); end
    checks++; if ({bus.pc_write, bus.reg_write_enable, bus.mem_write_enable, bus.mem_to_reg, bus.take_jump_next} !== 5'b0)
      begin errors++; $display("FAIL rst_strobes got=%b exp=00000", {bus.pc_write, bus.reg_write_enable, bus.mem_write_enable, bus.mem_to_reg, bus.take_jump_next}); end
    resetn = 1'b1;
    step();
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL id_state got=%0d exp=1", bus.state); end
    checks++; if ({bus.alu_sel_a, bus.alu_sel_b, bus.mem_read_enable, bus.pc_write, bus.reg_write_enable} !== 5'b11000)
      begin errors++; $display("FAIL id_ctrl got=%b exp=11000", {bus.alu_sel_a, bus.alu_sel_b, bus.mem_read_enable, bus.pc_write, bus.reg_write_enable}); end
    step();
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL pre_rst_ex got=%0d exp=2", bus.state); end
    resetn = 1'b0;
    #1;
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL async_rst got=%0d exp=0", bus.state); end
    checks++; if (bus.mem_read_enable !== 1'b1) begin errors++; $display("FAIL async_rst_mem_rd got=%b exp=1", bus.mem_read_enable); end
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_seq [5];
    exp_seq = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    bus.instruction = 32'h002081B3;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.state !== exp_seq[i]) begin errors++; $display("FAIL add_seq[%0d] got=%0d exp=%0d", i, bus.state, exp_seq[i]); end
      if (i < 4) step();
    end
  endtask

  task automatic test_add_sub();
    bus.instruction = 32'h402081B3;
    bus.src_a = 32'd7;
    bus.src_b = 32'd5;
    #1;
    checks++; if (bus.alu_result !== 32'd12) begin errors++; $display("FAIL if_forced_add got=%h exp=0000000c", bus.alu_result); end
    bus.instruction = 32'h002081B3;
    step(); step();
    checks++; if (bus.alu_result !== 32'd12) begin errors++; $display("FAIL add got=%h exp=0000000c", bus.alu_result); end
    checks++; if ({bus.alu_sel_a, bus.alu_sel_b} !== 2'b00) begin errors++; $display("FAIL r_sel got=%b exp=00", {bus.alu_sel_a, bus.alu_sel_b}); end
    bus.instruction = 32'h402081B3;
    #1;
    checks++; if (bus.alu_result !== 32'd2) begin errors++; $display("FAIL sub got=%h exp=00000002", bus.alu_result); end
    bus.src_a = 32'd0;
    bus.src_b = 32'd1;
    #1;
    checks++; if (bus.alu_result !== 32'hFFFFFFFF) begin errors++; $display("FAIL sub_wrap got=%h exp=ffffffff", bus.alu_result); end
    checks++; if (bus.zero_flag !== 1'b0) begin errors++; $display("FAIL sub_wrap_zero got=%b exp=0", bus.zero_flag); end
    bus.src_a = 32'd5;
    bus.src_b = 32'd5;
    #1;
    checks++; if (bus.zero_flag !== 1'b1) begin errors++; $display("FAIL sub_zero got=%b exp=1", bus.zero_flag); end
    step();
    checks++; if ({bus.state, bus.pc_write, bus.reg_write_enable, bus.mem_to_reg} !== 6'b100110)
      begin errors++; $display("FAIL r_wb got=%b exp=100110", {bus.state, bus.pc_write, bus.reg_write_enable, bus.mem_to_reg}); end
    step();
  endtask

  task automatic test_shift();
    bus.instruction = 32'h4020D1B3;
    bus.src_a = 32'h80000000;
    bus.src_b = 32'd4;
    step(); step();
    checks++; if (bus.alu_result !== 32'hF8000000) begin errors++; $display("FAIL sra got=%h exp=f8000000", bus.alu_result); end
    bus.instruction = 32'h0020D1B3;
    #1;
    checks++; if (bus.alu_result !== 32'h08000000) begin errors++; $display("FAIL srl got=%h exp=08000000", bus.alu_result); end
    step(); step();
  endtask

  task automatic test_load();
    bus.instruction = 32'h0040A103;
    bus.src_a = 32'd100;
    bus.src_b = 32'd4;
    #1;
    checks++; if (bus.immediate !== 32'd4) begin errors++; $display("FAIL ld_imm got=%h exp=00000004", bus.immediate); end
    step(); step();
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL ld_ex got=%0d exp=2", bus.state); end
    checks++; if (bus.alu_result !== 32'd104) begin errors++; $display("FAIL ld_addr got=%h exp=00000068", bus.alu_result); end
    checks++; if ({bus.alu_sel_a, bus.alu_sel_b} !== 2'b01) begin errors++; $display("FAIL ld_sel got=%b exp=01", {bus.alu_sel_a, bus.alu_sel_b}); end
    step();
    checks++; if ({bus.state, bus.mem_read_enable, bus.reg_write_enable} !== 5'b01110)
      begin errors++; $display("FAIL ld_me got=%b exp=01110", {bus.state, bus.mem_read_enable, bus.reg_write_enable}); end
    step();
    checks++; if ({bus.state, bus.mem_to_reg, bus.reg_write_enable, bus.mem_read_enable} !== 6'b100110)
      begin errors++; $display("FAIL ld_wb got=%b exp=100110", {bus.state, bus.mem_to_reg, bus.reg_write_enable, bus.mem_read_enable}); end
    step();
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL ld_ret got=%0d exp=0", bus.state); end
  endtask

  task automatic test_store();
    bus.instruction = 32'hFE20AE23;
    #1;
    checks++; if (bus.immediate !== 32'hFFFFFFFC) begin errors++; $display("FAIL st_imm got=%h exp=fffffffc", bus.immediate); end
    step(); step();
    checks++; if ({bus.state, bus.mem_write_enable} !== 4'b0100) begin errors++; $display("FAIL st_ex got=%b exp=0100", {bus.state, bus.mem_write_enable}); end
    step();
    checks++; if ({bus.state, bus.mem_write_enable, bus.mem_read_enable, bus.reg_write_enable} !== 6'b011100)
      begin errors++; $display("FAIL st_me got=%b exp=011100", {bus.state, bus.mem_write_enable, bus.mem_read_enable, bus.reg_write_enable}); end
    step();
    checks++; if ({bus.state, bus.mem_write_enable, bus.pc_write} !== 5'b00000)
      begin errors++; $display("FAIL st_ret got=%b exp=00000", {bus.state, bus.mem_write_enable, bus.pc_write}); end
  endtask

  task automatic test_branch_jump();
    bus.instruction = 32'h00208463;
    bus.src_a = 32'd3;
    bus.src_b = 32'd3;
    #1;
    checks++; if (bus.immediate !== 32'd8) begin errors++; $display("FAIL beq_imm got=%h exp=00000008", bus.immediate); end
    step(); step();
    checks++; if (bus.take_jump_next !== 1'b1) begin errors++; $display("FAIL beq_taken got=%b exp=1", bus.take_jump_next); end
    bus.src_b = 32'd4;
    #1;
    checks++; if (bus.take_jump_next !== 1'b0) begin errors++; $display("FAIL beq_not_taken got=%b exp=0", bus.take_jump_next); end
    checks++; if (bus.alu_result !== 32'hFFFFFFFF) begin errors++; $display("FAIL br_sub got=%h exp=ffffffff", bus.alu_result); end
    bus.instruction = 32'h0020A463;
    bus.src_b = 32'd3;
    #1;
    checks++; if (bus.take_jump_next !== 1'b0) begin errors++; $display("FAIL br_reserved got=%b exp=0", bus.take_jump_next); end
    step();
    checks++; if ({bus.state, bus.reg_write_enable, bus.pc_write} !== 5'b10001)
      begin errors++; $display("FAIL br_wb got=%b exp=10001", {bus.state, bus.reg_write_enable, bus.pc_write}); end
    step();
    bus.instruction = 32'h008000EF;
    #1;
    checks++; if (bus.immediate !== 32'd8) begin errors++; $display("FAIL jal_imm got=%h exp=00000008", bus.immediate); end
    step(); step();
    checks++; if ({bus.take_jump_next, bus.alu_sel_a, bus.alu_sel_b} !== 3'b111)
      begin errors++; $display("FAIL jal_ex got=%b exp=111", {bus.take_jump_next, bus.alu_sel_a, bus.alu_sel_b}); end
    step();
    checks++; if ({bus.state, bus.reg_write_enable, bus.take_jump_next} !== 5'b10010)
      begin errors++; $display("FAIL jal_wb got=%b exp=10010", {bus.state, bus.reg_write_enable, bus.take_jump_next}); end
    step();
  endtask

  task automatic test_lui();
    bus.instruction = 32'h123450B7;
    bus.src_a = 32'd9;
    bus.src_b = 32'h12345000;
    #1;
    checks++; if (bus.immediate !== 32'h12345000) begin errors++; $display("FAIL lui_imm got=%h exp=12345000", bus.immediate); end
    step(); step();
    checks++; if (bus.alu_result !== 32'h12345000) begin errors++; $display("FAIL lui_pass got=%h exp=12345000", bus.alu_result); end
    step();
    checks++; if ({bus.state, bus.reg_write_enable} !== 4'b1001) begin errors++; $display("FAIL lui_wb got=%b exp=1001", {bus.state, bus.reg_write_enable}); end
    step();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_add_sub();
    test_shift();
    test_load();
    test_store();
    test_branch_jump();
    test_lui();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end
endmodule
